// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST pattern generator / sequencer.
// The signature register and CUT live outside this block; only their widths are fixed here.
package bist_pkg;

    localparam int SIG_W  = 3;
    localparam int LFSR_W = 3;
    localparam int CNT_W  = 4;

    localparam logic [LFSR_W-1:0] TPG_SEED_DEF = 3'b001;
    localparam logic [SIG_W-1:0]  ORA_SEED_DEF = 3'b000;
    localparam logic [SIG_W-1:0]  GOLDEN_AND   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_RUN   = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_e;

    // Fibonacci step, taps on bits 2 and 1; maximal period 7 from any nonzero value.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[1], v[0], v[2] ^ v[1]};
    endfunction

endpackage

// File: rtl/bist_lfsr3.sv
// 3-bit pattern LFSR: load has priority over step, otherwise the value holds.
// Only the two low bits leave the block; they are the CUT inputs.
module bist_lfsr3
    import bist_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RST_VAL = TPG_SEED_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    output logic [1:0]        ab
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= RST_VAL;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign ab = lfsr_q[1:0];

endmodule

// File: rtl/bist_tpg_ctrl.sv
// BIST sequencer: seeds the signature register, streams NUM_PAT LFSR patterns into the
// CUT, then compares the captured signature against GOLDEN and reports pass/fail.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   SEED  | load signature register and pattern LFSR, clear pattern count
//   RUN   | one pattern per cycle, signature register capturing
//   CHECK | signature final; register compare result
//   DONE  | result held; start launches another run
module bist_tpg_ctrl
    import bist_pkg::*;
#(
    parameter logic [LFSR_W-1:0] TPG_SEED = TPG_SEED_DEF,
    parameter logic [SIG_W-1:0]  ORA_SEED = ORA_SEED_DEF,
    parameter int                NUM_PAT  = 7,
    parameter logic [SIG_W-1:0]  GOLDEN   = GOLDEN_AND
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SIG_W-1:0] sig,
    output logic             a,
    output logic             b,
    output logic             ora_init,
    output logic             ora_en,
    output logic [SIG_W-1:0] ora_seed,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PAT - 1);

    bist_state_e      state_q;
    logic [CNT_W-1:0] count_q;
    logic             ora_init_q;
    logic             ora_en_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    logic             lfsr_load;
    logic             lfsr_step;
    logic [1:0]       pat_ab;

    assign lfsr_load = (state_q == ST_SEED);
    assign lfsr_step = (state_q == ST_RUN);

    bist_lfsr3 #(
        .RST_VAL (TPG_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (TPG_SEED),
        .ab    (pat_ab)
    );

    // Outputs are registered alongside the state so each one is a clean flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            ora_init_q <= 1'b0;
            ora_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_SEED;
                        ora_init_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_SEED: begin
                    state_q    <= ST_RUN;
                    count_q    <= '0;
                    ora_init_q <= 1'b0;
                    ora_en_q   <= 1'b1;
                end
                ST_RUN: begin
                    count_q <= count_q + 4'd1;
                    if (count_q == LAST_CNT) begin
                        state_q  <= ST_CHECK;
                        ora_en_q <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    state_q <= ST_DONE;
                    pass_q  <= (sig == GOLDEN);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
                ST_DONE: begin
                    if (start) begin
                        state_q    <= ST_SEED;
                        ora_init_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    ora_init_q <= 1'b0;
                    ora_en_q   <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    pass_q     <= 1'b0;
                end
            endcase
        end
    end

    assign a        = pat_ab[1];
    assign b        = pat_ab[0];
    assign ora_init = ora_init_q;
    assign ora_en   = ora_en_q;
    assign ora_seed = ORA_SEED;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;

endmodule

// File: tb/tb_bist_tpg_ctrl.sv
// Bench for bist_tpg_ctrl: an external signature register and faultable AND CUT close the
// loop; expected patterns and results come from the published pattern table.
module tb_bist_tpg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       start4 = 1'b0;
    logic [2:0] sig = 3'b000, sig4 = 3'b000;
    logic [2:0] ora_seed, ora_seed4;
    logic       a, b, ora_init, ora_en, busy, done, pass;
    logic       a4, b4, ora_init4, ora_en4, busy4, done4, pass4;
    logic       resp, resp4;
    int         fault_mode = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bist_tpg_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sig(sig),
        .a(a), .b(b), .ora_init(ora_init), .ora_en(ora_en), .ora_seed(ora_seed),
        .busy(busy), .done(done), .pass(pass)
    );

    bist_tpg_ctrl #(.NUM_PAT(4), .GOLDEN(3'b001)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sig(sig4),
        .a(a4), .b(b4), .ora_init(ora_init4), .ora_en(ora_en4), .ora_seed(ora_seed4),
        .busy(busy4), .done(done4), .pass(pass4)
    );

    // mode 0: good AND, 1: output stuck-at-0, 2: output stuck-at-1, 3: input a stuck-at-1
    function automatic logic cut_model(input int mode, input logic ia, input logic ib);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ib;
            default: return ia & ib;
        endcase
    endfunction

    function automatic logic [2:0] misr_step(input logic [2:0] p, input logic d);
        return {p[1], p[0] ^ p[2], p[2] ^ d};
    endfunction

    // Default-seed pattern table, repeating with period 7.
    function automatic logic [2:0] pat_at(input int k);
        case (k % 7)
            0:       return 3'b001;
            1:       return 3'b010;
            2:       return 3'b101;
            3:       return 3'b011;
            4:       return 3'b111;
            5:       return 3'b110;
            default: return 3'b100;
        endcase
    endfunction

    assign resp  = cut_model(fault_mode, a, b);
    assign resp4 = a4 & b4;

    always @(posedge clk) begin
        if (ora_init) sig <= ora_seed;
        else if (ora_en) sig <= misr_step(sig, resp);
        if (ora_init4) sig4 <= ora_seed4;
        else if (ora_en4) sig4 <= misr_step(sig4, resp4);
    end

    typedef struct packed {
        logic       pass;
        logic [2:0] sig;
        logic [7:0] lat;
    } res_t;

    logic [1:0] ab_q[$];
    logic [1:0] ab4_q[$];
    res_t       res_q[$];
    res_t       res4_q[$];

    task automatic chk(input bit ok, input string name, input int act, input int exp_v);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic push_run(input bit sel4, input int n, input int mode, input logic [2:0] golden);
        logic [2:0] p;
        logic [2:0] pt;
        res_t       e;
        p = 3'b000;
        for (int k = 0; k < n; k++) begin
            pt = pat_at(k);
            p  = misr_step(p, cut_model(mode, pt[1], pt[0]));
            if (sel4) ab4_q.push_back(pt[1:0]);
            else      ab_q.push_back(pt[1:0]);
        end
        e.pass = (p == golden);
        e.sig  = p;
        e.lat  = 8'(n + 2);
        if (sel4) res4_q.push_back(e);
        else      res_q.push_back(e);
    endtask

    // Monitor, default-parameter instance
    int         cyc = 0;
    logic       done_d = 1'b0;
    logic       pass_cur = 1'b0;
    logic [1:0] eab;
    res_t       er;

    always @(negedge clk) begin
        if (!rst_n) begin
            done_d = 1'b0;
        end else begin
            if (ora_init) cyc = 0;
            else          cyc++;
            if (ora_en) begin
                chk(busy == 1'b1, "busy_in_run", int'(busy), 1);
                if (ab_q.size() == 0) chk(1'b0, "unexpected_pattern", int'({a, b}), -1);
                else begin
                    eab = ab_q.pop_front();
                    chk({a, b} == eab, "pattern_ab", int'({a, b}), int'(eab));
                end
            end
            if (done && !done_d) begin
                if (res_q.size() == 0) chk(1'b0, "unexpected_done", 1, 0);
                else begin
                    er = res_q.pop_front();
                    chk(pass == er.pass, "pass", int'(pass), int'(er.pass));
                    chk(sig == er.sig, "signature", int'(sig), int'(er.sig));
                    chk(cyc == int'(er.lat), "done_latency", cyc, int'(er.lat));
                    pass_cur = er.pass;
                end
            end else if (done) begin
                chk(pass == pass_cur, "pass_hold", int'(pass), int'(pass_cur));
            end
            done_d = done;
        end
    end

    // Monitor, NUM_PAT=4 instance
    int         cyc4 = 0;
    logic       done4_d = 1'b0;
    logic [1:0] eab4;
    res_t       er4;

    always @(negedge clk) begin
        if (!rst_n) begin
            done4_d = 1'b0;
        end else begin
            if (ora_init4) cyc4 = 0;
            else           cyc4++;
            if (ora_en4) begin
                if (ab4_q.size() == 0) chk(1'b0, "np4_unexpected_pattern", int'({a4, b4}), -1);
                else begin
                    eab4 = ab4_q.pop_front();
                    chk({a4, b4} == eab4, "np4_pattern_ab", int'({a4, b4}), int'(eab4));
                end
            end
            if (done4 && !done4_d) begin
                if (res4_q.size() == 0) chk(1'b0, "np4_unexpected_done", 1, 0);
                else begin
                    er4 = res4_q.pop_front();
                    chk(pass4 == er4.pass, "np4_pass", int'(pass4), int'(er4.pass));
                    chk(sig4 == er4.sig, "np4_signature", int'(sig4), int'(er4.sig));
                    chk(cyc4 == int'(er4.lat), "np4_done_latency", cyc4, int'(er4.lat));
                end
            end
            done4_d = done4;
        end
    end

    task automatic wait_done(input bit sel4, input bit noise, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (sel4 ? done4 : done) seen = 1'b1;
            else if (noise) start = 1'($urandom_range(0, 1));
        end
        if (noise) start = 1'b0;
        if (!seen) chk(1'b0, {tag, "_timeout"}, 0, 1);
    endtask

    task automatic run_one(input int mode, input bit noise);
        fault_mode = mode;
        push_run(1'b0, 7, mode, 3'b111);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        wait_done(1'b0, noise, "run");
        start = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(ora_init == 1'b0, {tag, "_ora_init"}, int'(ora_init), 0);
        chk(ora_en == 1'b0, {tag, "_ora_en"}, int'(ora_en), 0);
        chk(busy == 1'b0, {tag, "_busy"}, int'(busy), 0);
        chk(done == 1'b0, {tag, "_done"}, int'(done), 0);
        chk(pass == 1'b0, {tag, "_pass"}, int'(pass), 0);
        chk({a, b} == 2'b01, {tag, "_ab"}, int'({a, b}), 1);
        chk(ora_seed == 3'b000, {tag, "_ora_seed"}, int'(ora_seed), 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("reset");
        chk(done4 == 1'b0 && busy4 == 1'b0, "np4_reset", int'({done4, busy4}), 0);
        #5 rst_n = 1'b1;

        // fault-free default run
        run_one(0, 1'b0);
        chk(sig == 3'b111, "default_sig", int'(sig), 7);
        chk(pass == 1'b1 && done == 1'b1, "default_pass_done", int'({done, pass}), 3);

        // fault injections on the CUT
        run_one(1, 1'b0);
        chk(pass == 1'b0, "sa0_pass", int'(pass), 0);
        run_one(2, 1'b0);
        chk(sig == 3'b000, "sa1_sig", int'(sig), 0);
        run_one(3, 1'b0);
        chk(pass == 1'b0, "a_sa1_pass", int'(pass), 0);

        // asynchronous reset after three patterns
        fault_mode = 0;
        push_run(1'b0, 7, 0, 3'b111);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midrun_reset");
        chk(ab_q.size() == 4, "patterns_before_reset", 7 - ab_q.size(), 3);
        ab_q.delete();
        res_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        run_one(0, 1'b0);
        chk(pass == 1'b1, "post_reset_pass", int'(pass), 1);

        // start held high: back-to-back runs with one DONE cycle between them
        begin
            int dn;
            fault_mode = 0;
            push_run(1'b0, 7, 0, 3'b111);
            push_run(1'b0, 7, 0, 3'b111);
            @(negedge clk) start = 1'b1;
            wait_done(1'b0, 1'b0, "b2b_first");
            dn = 1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (done) dn++;
                else break;
            end
            chk(dn == 1, "done_cycles_b2b", dn, 1);
            chk(ora_init == 1'b1, "seed_after_done", int'(ora_init), 1);
            start = 1'b0;
            wait_done(1'b0, 1'b0, "b2b_second");
            chk(pass == 1'b1, "b2b_second_pass", int'(pass), 1);
            repeat (2) @(negedge clk);
        end

        // NUM_PAT=4, GOLDEN=001 instance
        push_run(1'b1, 4, 0, 3'b001);
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        wait_done(1'b1, 1'b0, "np4");
        chk(sig4 == 3'b001, "np4_sig_const", int'(sig4), 1);
        chk(pass4 == 1'b1, "np4_pass_const", int'(pass4), 1);

        // randomized fault modes with start noise while busy
        for (int r = 0; r < 8; r++) begin
            run_one(int'($urandom_range(0, 3)), 1'b1);
        end

        repeat (3) @(negedge clk);
        chk(ab_q.size() == 0 && ab4_q.size() == 0, "pattern_queue_drained",
            ab_q.size() + ab4_q.size(), 0);
        chk(res_q.size() == 0 && res4_q.size() == 0, "result_queue_drained",
            res_q.size() + res4_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/bist_tpg_ctrl.md
# bist_tpg_ctrl

Test-pattern generator and BIST sequencer for the 2-input AND circuit-under-test (CUT). The block drives pattern bits `a`/`b` into the CUT and controls the 3-bit signature register (`init`/`en`/`seed`) that compresses the CUT response. At the end of a run it compares the signature against a golden value and reports pass/fail. It is the stimulus end of the BIST loop, opposite the response analyzer.

## Interface
- `TPG_SEED`, default 3'b001: LFSR load value at run start; must be nonzero.
- `ORA_SEED`, default 3'b000: value driven on `ora_seed`.
- `NUM_PAT`, default 7: patterns per run, range 1..15.
- `GOLDEN`, default 3'b111: fault-free signature for the defaults.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: run request; sampled only in IDLE and DONE.
- `sig` in 3: signature register output (`P`).
- `a`, `b` out 1 each: CUT inputs; `a = lfsr[1]`, `b = lfsr[0]`.
- `ora_init` out 1: signature register load strobe.
- `ora_en` out 1: signature register capture enable.
- `ora_seed` out 3: constant `ORA_SEED`.
- `busy` out 1: high in SEED, RUN and CHECK.
- `done` out 1: high in DONE.
- `pass` out 1: registered result of the last run; valid while `done` = 1.

## Operation
- States are IDLE, SEED, RUN, CHECK and DONE.
- Reset values: state = IDLE, lfsr = `TPG_SEED`, count = 0, and `ora_init`, `ora_en`, `busy`, `done`, `pass` = 0.
- IDLE:
  - Outputs are idle.
  - If `start` = 1, go to SEED.
- SEED (1 cycle):
  - Drive `ora_init` = 1 and `ora_en` = 0.
  - Load lfsr with `TPG_SEED` and clear count.
  - Go to RUN.
- RUN (`NUM_PAT` cycles):
  - Drive `ora_en` = 1.
  - Each cycle, update `lfsr <= {lfsr[1], lfsr[0], lfsr[2]^lfsr[1]}` (period 7) and `count <= count+1`.
  - When count = `NUM_PAT`-1, go to CHECK.
- CHECK (1 cycle):
  - Drive `ora_en` = 0.
  - Register `pass <= (sig == GOLDEN)`.
  - Go to DONE.
- DONE:
  - Hold `done` = 1 and `pass` stable; hold lfsr.
  - If `start` = 1, go to SEED and clear `done` and `pass`. Otherwise stay in DONE.
- `start` is ignored while busy; there is no abort input.
- Outputs `ora_init`, `ora_en`, `busy` and `done` are decoded from the state register (Moore), so they are glitch-free.
- The CUT is combinational. The signature register captures `a&b` at the same edge that advances the lfsr.
- The count width is 4 bits. `NUM_PAT` values above 7 repeat the LFSR sequence.

## Timing
- Let the edge that samples `start` = 1 in IDLE be E0.
  - SEED spans E0–E1. Its load of the signature register and lfsr lands at E1.
  - RUN spans E1–E(1+`NUM_PAT`). Capture k (k = 0..`NUM_PAT`-1) happens at E(2+k).
  - CHECK spans E(1+`NUM_PAT`)–E(2+`NUM_PAT`). `sig` already holds the final signature.
  - `done` and `pass` are valid from E(2+`NUM_PAT`). With defaults this is 9 edges after the start sample.
- Default pattern sequence (lfsr): 001, 010, 101, 011, 111, 110, 100.
  - As (a,b): 01, 10, 01, 11, 11, 10, 00. All four input combinations are covered.
  - Fault-free responses are 0,0,0,1,1,0,0, which give signature 3'b111.
- If `rst_n` is asserted mid-run, all outputs take their reset values immediately. The signature register has no reset, but the next run re-seeds it through SEED.
- `start` held high continuously produces back-to-back runs, with one DONE cycle between runs.

## Structure
- Shared package `bist_pkg` holds:
  - the state enum;
  - width constants `SIG_W` = 3 and `LFSR_W` = 3;
  - the default seeds and `GOLDEN_AND` = 3'b111.
- Sub-module `bist_lfsr3`: 3-bit Fibonacci LFSR with `load`, `seed` and `step` inputs. It holds its value when `step` = 0.
- The top level contains the FSM, the pattern counter, the compare logic and the output decode.

## Test plan
- Default fault-free run: pulse `start` with a real signature register and an AND CUT. The (a,b) sequence must match the Timing list, `sig` = 3'b111, and `done` = 1 with `pass` = 1 exactly 9 edges after the start sample.
- CUT output stuck-at-0: all responses are 0, so `sig` = 3'b000 and `pass` = 0.
- CUT output stuck-at-1: `sig` = 3'b000 after 7 captures and `pass` = 0. Also check input `a` stuck-at-1: responses become 1,0,1,1,1,0,0 and `pass` must be 0.
- Reset during RUN after 3 patterns: outputs clear asynchronously. A following `start` must give a full 7-pattern run and `pass` = 1.
- `start` held high through a whole run: the mid-run level is ignored. Exactly one DONE cycle occurs, then SEED. The second run also gives `pass` = 1.
- Set `NUM_PAT` = 4 and `GOLDEN` = 3'b001: responses are 0,0,0,1, so `sig` = 3'b001, `pass` = 1, and `done` arrives 6 edges after the start sample.
